fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Front end of the RV32I pipeline: owns the architectural fetch PC and issues instruction-memory requests.
- Presents fetched instructions and their PC to decode through a one-entry output buffer.
- Consumes the redirect (target PC plus mispredict flag) produced by the execute-stage branch resolver.
- On a redirect, drops wrong-path work, raises a one-cycle flush and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- redirect_valid_in  input  1  branch mispredicted or jump taken; sampled every edge.
- redirect_pc_in  input  32  redirect target.
- stall_in  input  1  decode cannot accept; holds the output buffer.
- imem_req_out  output  1  instruction-memory request.
- imem_addr_out  output  32  request address, word aligned.
- imem_gnt_in  input  1  request accepted this cycle (req & gnt = committed).
- imem_rvalid_in  input  1  response data valid.
- imem_rdata_in  input  32  response instruction word.
- instr_valid_out  output  1  output buffer holds a valid instruction.
- instr_out  output  32  instruction word.
- instr_pc_out  output  32  PC of instr_out.
- flush_out  output  1  one-cycle pulse; younger pipeline stages discard their contents.

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc=RESET_PC; state=IDLE.
  - instr_valid_out=0, instr_out=0, instr_pc_out=0, flush_out=0.
  - imem_req_out=0; imem_addr_out reflects pc.
- Alignment: target pc = redirect_pc_in with bits[1:0] forced to 0.
- Outstanding requests: at most one.
- States:
  - IDLE: imem_req_out=0. Moves to REQ on the next edge unconditionally; first request issues 1 cycle after reset release.
  - REQ: imem_req_out=1 only when the buffer is empty or drains this cycle (instr_valid_out=0 or stall_in=0); otherwise held low. imem_addr_out=pc. req & gnt -> WAIT.
  - WAIT: imem_req_out=0. On rvalid:
    - buffer loads instr_out=rdata, instr_pc_out=pc, instr_valid_out=1;
    - pc=pc+PC_STEP (mod 2^32, wraps 0xFFFF_FFFC -> 0);
    - next state REQ.
  - DROP: a wrong-path response is still owed. On rvalid: discard it and go to REQ; pc already holds the target.
- Output buffer:
  - Cleared (instr_valid_out=0) when stall_in=0 and no new load arrives.
  - Contents held while stall_in=1.
  - Load and drain in the same cycle: the load wins.
  - The REQ gating guarantees a response never arrives while the buffer is full.
- Redirect (redirect_valid_in=1 at an edge), in all cases:
  - pc=target; flush_out=1 for exactly the following cycle; instr_valid_out=0 (buffer cleared, a same-edge load suppressed).
  - Next state by current state:
    - IDLE -> REQ.
    - REQ without gnt -> REQ with the new address. Retargeting an uncommitted request is legal.
    - REQ with gnt in the same cycle -> DROP.
    - WAIT without rvalid -> DROP.
    - WAIT with rvalid in the same cycle -> response discarded, -> REQ.
    - DROP -> stays DROP (or REQ if rvalid now) with the newest target.
  - Back-to-back redirects: the last one wins; flush_out stays high while redirects continue.
- Throughput: 1 instruction per 2 cycles when gnt is immediate and rvalid follows 1 cycle later.
- Mid-operation reset: state returns to IDLE and any owed response is forgotten. Instruction memory shares rst_n, so it issues no stale rvalid.

Test Plan:
- Reset then free-running memory (gnt same cycle, rvalid +1), RESET_PC=0 -> imem_addr_out 0,4,8; instr_pc_out 0,4,8 with matching rdata; instr_valid_out first high 3 cycles after reset release.
- stall_in=1 for 5 cycles with the buffer full -> imem_req_out stays 0; instr_out/instr_pc_out stable; fetch resumes at the next PC after release; no instruction lost or duplicated.
- Redirect to 0x0000_0103 while in WAIT, rvalid 2 cycles later -> flush_out one-cycle pulse; response discarded (instr_valid_out stays 0); next request address 0x0000_0100.
- Redirect in the same cycle as rvalid -> instr_valid_out not set by that response; next imem_addr_out equals the target.
- Redirect during REQ with gnt withheld -> imem_addr_out switches to the target the following cycle; no DROP, no discarded response.
- PC at 0xFFFF_FFFC fetched -> next request address 0x0000_0000; mid-stream rst_n=0 for one cycle -> all outputs zero; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the fetch PC, issues single-outstanding imem requests,
// buffers one instruction for decode and handles execute-stage redirects.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        flush_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] target;
  logic        commit;
  logic        load;

  assign target        = {redirect_pc_in[31:2], 2'b00};
  assign imem_addr_out = pc;

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    imem_req_out = 1'b0;
    commit       = 1'b0;
    load         = 1'b0;

    // Request only when the buffer is empty or drains this cycle, so a
    // response can never arrive into a full buffer.
    if (state == REQ) begin
      imem_req_out = !instr_valid_out || !stall_in;
    end
    commit = imem_req_out && imem_gnt_in;

    unique case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (commit) begin
          state_next = redirect_valid_in ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_in) begin
          state_next = REQ;
          load       = !redirect_valid_in;
        end else if (redirect_valid_in) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid_in) begin
          state_next = REQ;
        end
      end
    endcase

    if (redirect_valid_in) begin
      pc_next = target;
    end else if (load) begin
      pc_next = pc + 32'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      instr_valid_out <= 1'b0;
      instr_out       <= '0;
      instr_pc_out    <= '0;
      flush_out       <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      flush_out <= redirect_valid_in;
      if (redirect_valid_in) begin
        instr_valid_out <= 1'b0;
      end else if (load) begin
        instr_valid_out <= 1'b1;
        instr_out       <= imem_rdata_in;
        instr_pc_out    <= pc;
      end else if (!stall_in) begin
        instr_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a small latency-programmable
// instruction-memory responder driven from the stimulus process.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        stall_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        flush_out;

  int unsigned checks;
  int unsigned passes;

  logic        gnt_en;
  logic        pend;
  logic [31:0] pend_addr;
  int unsigned cnt;
  int unsigned lat;

  fetch_pc_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .redirect_valid_in (redirect_valid_in),
    .redirect_pc_in    (redirect_pc_in),
    .stall_in          (stall_in),
    .imem_req_out      (imem_req_out),
    .imem_addr_out     (imem_addr_out),
    .imem_gnt_in       (imem_gnt_in),
    .imem_rvalid_in    (imem_rvalid_in),
    .imem_rdata_in     (imem_rdata_in),
    .instr_valid_out   (instr_valid_out),
    .instr_out         (instr_out),
    .instr_pc_out      (instr_pc_out),
    .flush_out         (flush_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive memory response, note any commit, advance to next negedge.
  task automatic tick();
    logic        commit;
    logic        rv;
    logic        rst_at_edge;
    logic [31:0] addr;
    imem_gnt_in    = gnt_en;
    imem_rvalid_in = rst_n && pend && (cnt == 1);
    imem_rdata_in  = imem_rvalid_in ? (pend_addr ^ 32'hA5A5_0000) : '0;
    #1;
    commit      = imem_req_out && imem_gnt_in;
    addr        = imem_addr_out;
    rv          = imem_rvalid_in;
    rst_at_edge = rst_n;
    @(posedge clk);
    @(negedge clk);
    if (!rst_at_edge) begin
      pend = 1'b0;
    end else begin
      if (rv) pend = 1'b0;
      else if (pend) cnt--;
      if (commit) begin
        pend      = 1'b1;
        pend_addr = addr;
        cnt       = lat;
      end
    end
  endtask

  initial begin
    checks = 0; passes = 0;
    rst_n = 1'b0; redirect_valid_in = 1'b0; redirect_pc_in = '0; stall_in = 1'b0;
    imem_gnt_in = 1'b0; imem_rvalid_in = 1'b0; imem_rdata_in = '0;
    gnt_en = 1'b1; pend = 1'b0; pend_addr = '0; cnt = 0; lat = 1;

    repeat (3) tick();
    chk("rst_valid", 32'(instr_valid_out), 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_ipc", instr_pc_out, 32'd0);
    chk("rst_flush", 32'(flush_out), 32'd0);
    chk("rst_req", 32'(imem_req_out), 32'd0);
    chk("rst_addr", imem_addr_out, 32'd0);

    // Free-running fetch from RESET_PC
    rst_n = 1'b1;
    tick();
    chk("first_req", 32'(imem_req_out), 32'd1);
    chk("first_addr", imem_addr_out, 32'h0);
    tick();
    chk("wait_req", 32'(imem_req_out), 32'd0);
    chk("wait_valid", 32'(instr_valid_out), 32'd0);
    tick();
    chk("i0_valid", 32'(instr_valid_out), 32'd1);
    chk("i0_pc", instr_pc_out, 32'h0);
    chk("i0_data", instr_out, 32'hA5A5_0000);
    chk("addr4", imem_addr_out, 32'h4);
    tick();
    chk("drain_valid", 32'(instr_valid_out), 32'd0);
    tick();
    chk("i1_pc", instr_pc_out, 32'h4);
    chk("i1_data", instr_out, 32'hA5A5_0004);
    chk("addr8", imem_addr_out, 32'h8);
    tick(); tick();
    chk("i2_valid", 32'(instr_valid_out), 32'd1);
    chk("i2_pc", instr_pc_out, 32'h8);
    chk("i2_data", instr_out, 32'hA5A5_0008);

    // Stall with a full buffer
    stall_in = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", 32'(imem_req_out), 32'd0);
      chk("stall_ipc", instr_pc_out, 32'h8);
      chk("stall_valid", 32'(instr_valid_out), 32'd1);
      tick();
    end
    chk("stall_data", instr_out, 32'hA5A5_0008);
    stall_in = 1'b0;
    #1;
    chk("resume_req", 32'(imem_req_out), 32'd1);
    chk("resume_addr", imem_addr_out, 32'hC);
    tick(); tick();
    chk("i3_pc", instr_pc_out, 32'hC);
    chk("i3_data", instr_out, 32'hA5A5_000C);

    // Redirect in WAIT with the response arriving two cycles after grant
    lat = 2;
    tick();
    lat = 1;
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h0000_0103;
    tick();
    redirect_valid_in = 1'b0;
    chk("rw_flush", 32'(flush_out), 32'd1);
    chk("rw_valid", 32'(instr_valid_out), 32'd0);
    chk("rw_drop_req", 32'(imem_req_out), 32'd0);
    tick();
    chk("rw_flush_end", 32'(flush_out), 32'd0);
    chk("rw_discard", 32'(instr_valid_out), 32'd0);
    chk("rw_req", 32'(imem_req_out), 32'd1);
    chk("rw_addr", imem_addr_out, 32'h100);

    // Redirect coinciding with rvalid
    tick();
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h0000_0200;
    tick();
    redirect_valid_in = 1'b0;
    chk("rv_valid", 32'(instr_valid_out), 32'd0);
    chk("rv_flush", 32'(flush_out), 32'd1);
    chk("rv_req", 32'(imem_req_out), 32'd1);
    chk("rv_addr", imem_addr_out, 32'h200);

    // Redirect during REQ while grant is withheld
    gnt_en = 1'b0;
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h0000_0300;
    tick();
    redirect_valid_in = 1'b0; gnt_en = 1'b1;
    chk("rq_req", 32'(imem_req_out), 32'd1);
    chk("rq_addr", imem_addr_out, 32'h300);
    tick(); tick();
    chk("rq_valid", 32'(instr_valid_out), 32'd1);
    chk("rq_pc", instr_pc_out, 32'h300);
    chk("rq_data", instr_out, 32'hA5A5_0300);

    // PC wrap at the top of the address space
    gnt_en = 1'b0;
    redirect_valid_in = 1'b1; redirect_pc_in = 32'hFFFF_FFFC;
    tick();
    redirect_valid_in = 1'b0; gnt_en = 1'b1;
    tick(); tick();
    chk("wrap_pc", instr_pc_out, 32'hFFFF_FFFC);
    chk("wrap_data", instr_out, 32'h5A5A_FFFC);
    chk("wrap_addr", imem_addr_out, 32'h0);

    // Reset mid-stream with a response owed
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid", 32'(instr_valid_out), 32'd0);
    chk("mrst_instr", instr_out, 32'd0);
    chk("mrst_ipc", instr_pc_out, 32'd0);
    chk("mrst_flush", 32'(flush_out), 32'd0);
    chk("mrst_req", 32'(imem_req_out), 32'd0);
    chk("mrst_addr", imem_addr_out, 32'd0);
    tick();
    chk("restart_req", 32'(imem_req_out), 32'd1);
    chk("restart_addr", imem_addr_out, 32'h0);
    tick(); tick();
    chk("restart_pc", instr_pc_out, 32'h0);
    chk("restart_data", instr_out, 32'hA5A5_0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
